// File: rtl/mul_share_sched_if.sv
// Request, shared-multiplier and tagged-response signals of mul_share_sched.
// The scheduler takes the slave side; clients plus the multiplier take the master side.
interface mul_share_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic [15:0]        mul_a;
  logic [15:0]        mul_b;
  logic [31:0]        mul_p;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_data;
  logic [2:0]         inflight;
  logic               busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_p,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, inflight, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_p,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, inflight, busy
  );
endinterface

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one 16x16 signed multiplier among NREQ clients.
// Each product is rescaled by an arithmetic shift and returned with its requester tag.
module mul_share_sched #(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int SHIFT_WIDTH = 12,
  parameter int LAT         = 1
) (
  input logic              clk,
  input logic              rst_n,
  input logic              en,
  mul_share_sched_if.slave bus
);
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id0;
  logic            r_v0;
  logic [15:0]     r_mul_a;
  logic [15:0]     r_mul_b;
  logic            r_pv  [1:LAT];
  logic [IDW-1:0]  r_pid [1:LAT];
  logic [31:0]     r_pd  [1:LAT];
  logic [2:0]      r_inflight;
  logic            r_busy;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gid;
  logic [IDW-1:0]  w_cand;
  logic            w_hs;
  logic            w_hit;
  logic [31:0]     w_scaled;
  logic [2:0]      w_inflight_nxt;

  // Round-robin search: first valid requester strictly after the last winner.
  always_comb begin
    int c;
    c       = 0;
    w_cand  = '0;
    w_hit   = 1'b0;
    w_grant = '0;
    w_gid   = '0;
    w_hs    = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      c      = (int'(r_ptr) + k) % NREQ;
      w_cand = IDW'(c);
      w_hit  = en && rst_n && !w_hs && bus.req_valid[w_cand];
      w_grant[w_cand] = w_grant[w_cand] | w_hit;
      w_gid  = w_hit ? w_cand : w_gid;
      w_hs   = w_hs | w_hit;
    end
  end

  // Rescale and occupancy bookkeeping feeding the registers.
  always_comb begin
    w_scaled       = $signed(bus.mul_p) >>> SHIFT_WIDTH;
    w_inflight_nxt = r_inflight + {2'b00, w_hs} - {2'b00, r_pv[LAT]};
  end

  // Issue stage, result pipeline and status; en=0 freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr      <= IDW'(NREQ - 1);
      r_v0       <= 1'b0;
      r_id0      <= '0;
      r_mul_a    <= 16'h0000;
      r_mul_b    <= 16'h0000;
      r_inflight <= 3'd0;
      r_busy     <= 1'b0;
      for (int s = 1; s <= LAT; s++) begin
        r_pv[s]  <= 1'b0;
        r_pid[s] <= '0;
        r_pd[s]  <= 32'h0000_0000;
      end
    end else if (en) begin
      r_v0 <= w_hs;
      if (w_hs) begin
        r_ptr   <= w_gid;
        r_id0   <= w_gid;
        r_mul_a <= bus.req_a[16*w_gid +: 16];
        r_mul_b <= bus.req_b[16*w_gid +: 16];
      end else begin
        r_ptr   <= r_ptr;
      end
      r_pv[1]  <= r_v0;
      r_pid[1] <= r_id0;
      r_pd[1]  <= w_scaled;
      for (int s = 2; s <= LAT; s++) begin
        r_pv[s]  <= r_pv[s-1];
        r_pid[s] <= r_pid[s-1];
        r_pd[s]  <= r_pd[s-1];
      end
      r_inflight <= w_inflight_nxt;
      r_busy     <= (w_inflight_nxt != 3'd0);
    end else begin
      r_busy <= r_busy;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.mul_a     = r_mul_a;
  assign bus.mul_b     = r_mul_b;
  assign bus.rsp_valid = r_pv[LAT];
  assign bus.rsp_id    = r_pid[LAT];
  assign bus.rsp_data  = r_pd[LAT];
  assign bus.inflight  = r_inflight;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_mul_share_sched.sv
// Randomised plus directed bench for mul_share_sched with a queue-based reference model.
// Expected responses are queued at issue and popped by a negedge monitor.
module tb_mul_share_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int SW   = 12;
  localparam int LAT  = 2;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          remain;
  } op_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic chk_on = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  op_t             q[$];
  int              m_ptr = NREQ - 1;
  logic [15:0]     m_a   = 16'h0000;
  logic [15:0]     m_b   = 16'h0000;
  logic [NREQ-1:0] m_grant;
  int              m_gid;
  logic            m_exp_valid;

  mul_share_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  // Exact signed multiplier standing in for the shared instance.
  assign bus.mul_p = $signed({{16{bus.mul_a[15]}}, bus.mul_a}) *
                     $signed({{16{bus.mul_b[15]}}, bus.mul_b});

  mul_share_sched #(.NREQ(NREQ), .IDW(IDW), .SHIFT_WIDTH(SW), .LAT(LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // floor(a*b / 2**SW) by integer division with explicit floor correction
  function automatic logic [31:0] ref_rescale(input logic [15:0] a, input logic [15:0] b);
    longint p, d, qv;
    p  = longint'($signed(a)) * longint'($signed(b));
    d  = longint'(1) << SW;
    qv = p / d;
    if ((p % d) != 0 && p < 0) qv = qv - 1;
    return qv[31:0];
  endfunction

  // Monitor compares the presented outputs, then the issue tracker advances the model.
  always @(negedge clk) begin
    if (chk_on) begin
      m_exp_valid = (q.size() > 0) && (q[0].remain == 0);
      chk("rsp_valid", bus.rsp_valid, m_exp_valid);
      chk("inflight", bus.inflight, q.size());
      chk("busy", bus.busy, q.size() != 0);
      chk("mul_a", bus.mul_a, m_a);
      chk("mul_b", bus.mul_b, m_b);
      if (m_exp_valid) begin
        chk("rsp_id", bus.rsp_id, q[0].id);
        chk("rsp_data", bus.rsp_data, q[0].data);
        if (en && rst_n) void'(q.pop_front());
      end

      m_grant = '0;
      m_gid   = -1;
      if (en && rst_n) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (m_gid < 0 && bus.req_valid[(m_ptr + k) % NREQ]) m_gid = (m_ptr + k) % NREQ;
        end
        if (m_gid >= 0) m_grant[m_gid] = 1'b1;
      end
      chk("req_ready", bus.req_ready, m_grant);

      if (!rst_n) begin
        q.delete();
        m_ptr = NREQ - 1;
        m_a   = 16'h0000;
        m_b   = 16'h0000;
      end else if (en) begin
        foreach (q[i]) if (q[i].remain > 0) q[i].remain--;
        if (m_gid >= 0) begin
          m_a = bus.req_a[16*m_gid +: 16];
          m_b = bus.req_b[16*m_gid +: 16];
          q.push_back('{id: m_gid, data: ref_rescale(m_a, m_b), remain: LAT});
          m_ptr = m_gid;
        end
      end
    end
  end

  task automatic step(input logic [NREQ-1:0] v);
    bus.req_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[16*i +: 16] = a;
    bus.req_b[16*i +: 16] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) set_op(i, 16'($urandom), 16'($urandom));
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    @(negedge clk);
    chk("reset_rsp_id", bus.rsp_id, 0);
    chk("reset_rsp_data", bus.rsp_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;

    // single op, then sign/floor corner cases
    set_op(2, 16'd100, -16'sd8123);
    step(4'b0100);
    repeat (4) step(4'b0000);
    set_op(0, -16'sd1, 16'sd1);
    set_op(1, 16'sd32767, 16'sd32767);
    step(4'b0011);
    step(4'b0010);
    repeat (4) step(4'b0000);

    // all requesters valid: strict rotation, back-to-back responses
    for (int c = 0; c < 8; c++) begin
      rand_ops();
      step(4'b1111);
    end
    repeat (4) step(4'b0000);

    // wrap and skip after the last grant went to requester 3
    rand_ops();
    step(4'b0010);
    step(4'b1001);
    step(4'b0001);
    repeat (4) step(4'b0000);

    // stall with two operations in flight
    rand_ops();
    step(4'b0001);
    step(4'b0010);
    en = 1'b0;
    repeat (3) step(4'b1111);
    en = 1'b1;
    repeat (5) step(4'b0000);

    // reset right after two handshakes discards both
    rand_ops();
    step(4'b0100);
    step(4'b1000);
    rst_n = 1'b0;
    step(4'b0000);
    rst_n = 1'b1;
    step(4'b1111);
    repeat (5) step(4'b0000);

    // randomised traffic, stalls and rare resets
    for (int c = 0; c < 400; c++) begin
      rand_ops();
      en    = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      step(4'($urandom));
    end
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (8) step(4'b0000);
    chk("drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
